// File: rtl/prog_scheduler.sv
// prog_scheduler: round-robin time-slice scheduler for the partitioned data RAM; quantum preemption under SCHED_PREEMPT_EN
module prog_scheduler #(
  parameter int NUM_PROGS = 10,
  parameter int QUANTUM = 64,
  parameter int QW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [3:0] load_idx,
  input  logic       os_return,
  input  logic       syscall,
  input  logic       prog_done,
  output logic [3:0] progIndex,
  output logic       OSUsage,
  output logic [1:0] trap_cause,
  output logic       ctx_switch,
  output logic       idle
);
  typedef enum logic [1:0] {S_OS, S_PICK, S_RUN} state_t;
  state_t state, state_n;
  logic [NUM_PROGS-1:0] mask, mask_n, rot;
  logic [3:0] base, pick;
  logic [1:0] cause_n;
  logic fresh, expire;
`ifdef SCHED_PREEMPT_EN
  logic [QW-1:0] cnt;
  assign expire = cnt == '0;
  // quantum counter: reloaded when a program is picked, counts down while it runs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == S_PICK) cnt <= QW'(QUANTUM - 1);
    else if (state == S_RUN && cnt != '0) cnt <= cnt - QW'(1);
`else
  assign expire = 1'b0;
`endif
  // round-robin search after the last program (current one last); before the first pick it starts at 0
  always_comb begin
    base = fresh ? 4'(NUM_PROGS - 1) : progIndex;
    rot = NUM_PROGS'({mask, mask} >> (base + 4'd1));
    pick = '0;
    for (int i = NUM_PROGS - 1; i >= 0; i--)
      if (rot[i]) pick = 4'((int'(base) + 1 + i) % NUM_PROGS);
  end
  // next state, mask update and trap cause; a load beats a clearing completion on the same bit
  always_comb begin
    state_n = state;
    cause_n = trap_cause;
    mask_n = mask;
    if (state == S_RUN && prog_done) mask_n[progIndex] = 1'b0;
    if (load_en && int'(load_idx) < NUM_PROGS) mask_n[load_idx] = 1'b1;
    case (state)
      S_OS: state_n = os_return && |mask ? S_PICK : S_OS;
      S_PICK: begin
        state_n = |mask ? S_RUN : S_OS;
        cause_n = |mask ? 2'd0 : trap_cause;
      end
      S_RUN: begin
        cause_n = prog_done ? 2'd3 : syscall ? 2'd2 : expire ? 2'd1 : 2'd0;
        state_n = cause_n != 2'd0 ? S_OS : S_RUN;
      end
      default: state_n = S_OS;
    endcase
  end
  // registered state and outputs; progIndex only moves on the pick-to-run edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_OS;
      mask <= '0;
      fresh <= 1'b1;
      progIndex <= '0;
      OSUsage <= 1'b1;
      trap_cause <= '0;
      ctx_switch <= 1'b0;
      idle <= 1'b1;
    end else begin
      state <= state_n;
      mask <= mask_n;
      trap_cause <= cause_n;
      OSUsage <= state_n != S_RUN;
      ctx_switch <= state == S_RUN && state_n == S_OS;
      idle <= state_n == S_OS && mask_n == '0;
      if (state == S_PICK && state_n == S_RUN) begin
        progIndex <= pick;
        fresh <= 1'b0;
      end
    end
endmodule

// File: tb/tb_prog_scheduler.sv
// tb_prog_scheduler: scoreboard bench for prog_scheduler picks, slice lengths, trap causes and mask handling
module tb_prog_scheduler;
  localparam int N = 10;
  localparam int QUANTUM = 64;
`ifdef SCHED_PREEMPT_EN
  localparam int QM = 0;
`else
  localparam int QM = 1;
`endif
  logic clk = 0, rst_n = 0, load_en = 0, os_return = 0, syscall = 0, prog_done = 0;
  logic [3:0] load_idx = 0, progIndex;
  logic OSUsage, ctx_switch, idle;
  logic [1:0] trap_cause;
  logic [N-1:0] m = '0;
  int last = 0, passed = 0, total = 0;
  bit fresh = 1;
  int q[$], cq[$];

  prog_scheduler dut (.clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx),
    .os_return(os_return), .syscall(syscall), .prog_done(prog_done), .progIndex(progIndex),
    .OSUsage(OSUsage), .trap_cause(trap_cause), .ctx_switch(ctx_switch), .idle(idle));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pick_model();
    int b;
    b = fresh ? N - 1 : last;
    for (int i = 1; i <= N; i++)
      if (((m >> ((b + i) % N)) & 10'd1) != 0) return (b + i) % N;
    return -1;
  endfunction

  task automatic load(input int idx);
    load_en = 1;
    load_idx = 4'(idx);
    @(negedge clk);
    load_en = 0;
    if (idx < N) m[idx] = 1'b1;
  endtask

  task automatic os_empty();
    os_return = 1;
    @(negedge clk);
    os_return = 0;
    repeat (2) @(negedge clk);
    chk("empty_osu", int'(OSUsage), 1);
    chk("empty_idle", int'(idle), 1);
  endtask

  // mode: 0 quantum expiry, 1 syscall, 2 done, 3 syscall+done, 4 reset; len = RUN cycle of the event
  task automatic slice(input int mode, input int len, input bit ld3);
    int n, cs, e;
    q.push_back(pick_model());
    if (mode == 0) cq.push_back(1);
    os_return = 1;
    @(negedge clk);
    os_return = 0;
    chk("pick_osu", int'(OSUsage), 1);
    @(negedge clk);
    chk("run_osu", int'(OSUsage), 0);
    chk("run_cause", int'(trap_cause), 0);
    e = q.size() != 0 ? q.pop_front() : -1;
    chk("prog_idx", int'(progIndex), e);
    last = e;
    fresh = 0;
    n = 0;
    cs = 0;
    while (OSUsage == 0 && n < 300) begin
      n++;
      if (mode != 0 && n == len) begin
        if (mode == 4) begin
          rst_n = 0;
          #1;
          chk("rst_osu", int'(OSUsage), 1);
          chk("rst_idx", int'(progIndex), 0);
          chk("rst_idle", int'(idle), 1);
          chk("rst_ctx", int'(ctx_switch), 0);
          chk("rst_cause", int'(trap_cause), 0);
          m = '0;
          fresh = 1;
          last = 0;
          q.delete();
          cq.delete();
          @(negedge clk);
          rst_n = 1;
          return;
        end
        syscall = mode[0];
        prog_done = mode[1];
        if (ld3) begin
          load_en = 1;
          load_idx = 4'd3;
        end
        cq.push_back(mode == 1 ? 2 : 3);
        if (mode >= 2) m[last] = 1'b0;
        if (ld3) m[3] = 1'b1;
      end
      @(negedge clk);
      syscall = 0;
      prog_done = 0;
      load_en = 0;
      if (ctx_switch) begin
        cs++;
        e = cq.size() != 0 ? cq.pop_front() : -1;
        chk("cause", int'(trap_cause), e);
      end
    end
    chk("slice_len", n, mode == 0 ? QUANTUM : len);
    @(negedge clk);
    if (ctx_switch) cs++;
    chk("ctx_count", cs, 1);
    chk("os_after", int'(OSUsage), 1);
    chk("idle_after", int'(idle), m == '0 ? 1 : 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_osu", int'(OSUsage), 1);
    chk("reset_idx", int'(progIndex), 0);
    chk("reset_idle", int'(idle), 1);
    chk("reset_ctx", int'(ctx_switch), 0);
    chk("reset_cause", int'(trap_cause), 0);
    rst_n = 1;
    @(negedge clk);
    os_empty();
    load(12);
    @(negedge clk);
    chk("load12_idle", int'(idle), 1);
    load(0);
    load(3);
    load(7);
    chk("loaded_idle", int'(idle), 0);
    repeat (4) slice(QM, 64, 0);
    slice(3, 10, 0);
    repeat (3) slice(QM, 64, 0);
    load(3);
    slice(QM, 64, 0);
    slice(2, 5, 1);
    repeat (3) slice(QM, 64, 0);
    repeat (3) slice(2, 3, 0);
    os_empty();
    load(9);
    repeat (2) slice(QM, 64, 0);
`ifndef SCHED_PREEMPT_EN
    slice(1, 200, 0);
`endif
    slice(4, 20, 0);
    @(negedge clk);
    os_empty();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
